// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage of the accumulator CPU. It accepts a
//               fetch request from pc_reg and runs a read handshake with
//               instruction memory. The returned word is latched into the
//               instruction register and handed to decode with a valid/stall
//               handshake. busy_o tells the pc unit to hold its request.
//               Optional macro FETCH_TIMEOUT_EN bounds the memory wait. On
//               expiry it loads NOP_WORD and sets the sticky fault_o flag.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 8,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic                     rmem_i,
  output logic                     busy_o,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic [DATA_W-1:0]        ir_o,
  output logic [DATA_W-ADDR_W-1:0] opcode_o,
  output logic [ADDR_W-1:0]        operand_o,
  output logic                     valid_o,
  input  logic                     stall_i,
  output logic                     fault_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t r_state;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] r_wait_cnt;
`else
  // Timeout settings have no effect in this build; fold them into a dead wire.
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT != 0) ^ (NOP_WORD != '0);
`endif

  // Hold-off for the pc unit: a fetch is in flight, or decode has not taken
  // the current instruction yet.
  assign busy_o = (r_state == S_WAIT) | ((r_state == S_FULL) & stall_i);

  // Decode fields are plain slices of the instruction register.
  assign opcode_o  = ir_o[DATA_W-1:ADDR_W];
  assign operand_o = ir_o[ADDR_W-1:0];

  // Fetch control FSM with all memory/decode-facing outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      ir_o       <= '0;
      valid_o    <= 1'b0;
      fault_o    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rmem_i) begin
            mem_addr   <= pc_i;
            mem_rd     <= 1'b1;
            r_state    <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end

        S_WAIT: begin
          // Returned data takes priority over an expiring timeout.
          if (mem_ready) begin
            ir_o    <= mem_rdata;
            valid_o <= 1'b1;
            mem_rd  <= 1'b0;
            r_state <= S_FULL;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_wait_cnt == C_CNT_LAST) begin
            ir_o    <= NOP_WORD;
            valid_o <= 1'b1;
            mem_rd  <= 1'b0;
            fault_o <= 1'b1;
            r_state <= S_FULL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end

        S_FULL: begin
          if (!stall_i) begin
            valid_o <= 1'b0;
            // Back-to-back fetch when the pc already has the next request.
            if (rmem_i) begin
              mem_addr   <= pc_i;
              mem_rd     <= 1'b1;
              r_state    <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
              r_wait_cnt <= '0;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          mem_rd  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed self-checking bench for inst_fetch. Stimulus is a
//               linear sequence of steps. Each expected value is hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic       clock;
  logic       reset;
  logic [4:0] pc_i;
  logic       rmem_i;
  logic       busy_o;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [7:0] ir_o;
  logic [2:0] opcode_o;
  logic [4:0] operand_o;
  logic       valid_o;
  logic       stall_i;
  logic       fault_o;

  int checks   = 0;
  int failures = 0;

  inst_fetch #(
    .ADDR_W  (5),
    .DATA_W  (8),
    .TIMEOUT (15),
    .NOP_WORD(8'h00)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pc_i     (pc_i),
    .rmem_i   (rmem_i),
    .busy_o   (busy_o),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .ir_o     (ir_o),
    .opcode_o (opcode_o),
    .operand_o(operand_o),
    .valid_o  (valid_o),
    .stall_i  (stall_i),
    .fault_o  (fault_o)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    rmem_i    = 1'b1;
    mem_ready = 1'b1;
    pc_i      = 5'd3;
    mem_rdata = 8'h55;
    stall_i   = 1'b0;

    // Reset held with active requests: everything stays cleared.
    #3;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fault", fault_o, 0);
    step();
    step();
    chk("rst_hold_mem_rd", mem_rd, 0);
    chk("rst_hold_valid", valid_o, 0);

    // Release reset: first fetch starts at the next edge.
    reset = 1'b1;
    step();
    chk("first_mem_rd", mem_rd, 1);
    chk("first_addr", mem_addr, 3);
    chk("first_busy", busy_o, 1);
    rmem_i = 1'b0;
    step();
    chk("first_ir", ir_o, 8'h55);
    chk("first_valid", valid_o, 1);
    mem_ready = 1'b0;
    step();
    chk("first_consumed", valid_o, 0);

    // Single fetch of address 15.
    pc_i   = 5'd15;
    rmem_i = 1'b1;
    step();
    chk("sf_mem_rd", mem_rd, 1);
    chk("sf_addr", mem_addr, 15);
    chk("sf_valid0", valid_o, 0);
    rmem_i    = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 8'hAF;
    step();
    chk("sf_ir", ir_o, 8'hAF);
    chk("sf_opcode", opcode_o, 3'b101);
    chk("sf_operand", operand_o, 5'h0F);
    chk("sf_valid", valid_o, 1);
    chk("sf_mem_rd_off", mem_rd, 0);
    chk("sf_busy_nostall", busy_o, 0);
    mem_ready = 1'b0;
    step();
    chk("sf_valid_clr", valid_o, 0);
    chk("sf_ir_kept", ir_o, 8'hAF);
    chk("sf_idle_busy", busy_o, 0);

    // Wait states with an ignored request pulse in the middle.
    pc_i   = 5'd7;
    rmem_i = 1'b1;
    step();
    rmem_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ws_mem_rd", mem_rd, 1);
      chk("ws_addr", mem_addr, 7);
      chk("ws_busy", busy_o, 1);
      chk("ws_valid", valid_o, 0);
      if (i == 1) begin
        pc_i   = 5'd20;
        rmem_i = 1'b1;
      end else begin
        rmem_i = 1'b0;
      end
      step();
    end
    chk("ws_addr_end", mem_addr, 7);
    rmem_i    = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 8'h3C;
    stall_i   = 1'b1;
    step();
    chk("ws_ir", ir_o, 8'h3C);
    chk("ws_valid_end", valid_o, 1);
    mem_ready = 1'b0;

    // Stall in FULL for three cycles.
    for (int i = 0; i < 3; i++) begin
      chk("st_busy", busy_o, 1);
      chk("st_ir", ir_o, 8'h3C);
      chk("st_valid", valid_o, 1);
      step();
    end

    // Release the stall with a back-to-back request.
    stall_i = 1'b0;
    rmem_i  = 1'b1;
    pc_i    = 5'd16;
    #1;
    chk("b2b_busy_free", busy_o, 0);
    step();
    chk("b2b_mem_rd", mem_rd, 1);
    chk("b2b_addr", mem_addr, 16);
    chk("b2b_valid", valid_o, 0);
    rmem_i = 1'b0;

    // Reset mid-fetch, then a late mem_ready must be ignored.
    #2;
    reset = 1'b0;
    #1;
    chk("rmf_mem_rd", mem_rd, 0);
    chk("rmf_addr", mem_addr, 0);
    chk("rmf_busy", busy_o, 0);
    step();
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 8'hEE;
    step();
    chk("rmf_late_valid", valid_o, 0);
    chk("rmf_late_ir", ir_o, 0);
    chk("rmf_late_mem_rd", mem_rd, 0);
    mem_ready = 1'b0;
    step();

`ifdef FETCH_TIMEOUT_EN
    // mem_ready arriving on the last allowed cycle wins over the timeout.
    pc_i   = 5'd9;
    rmem_i = 1'b1;
    step();
    rmem_i = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("to_race_waiting", mem_rd, 1);
    mem_ready = 1'b1;
    mem_rdata = 8'h41;
    step();
    chk("to_race_ir", ir_o, 8'h41);
    chk("to_race_fault", fault_o, 0);
    mem_ready = 1'b0;
    step();

    // No mem_ready at all: timeout after 15 WAIT cycles.
    pc_i   = 5'd31;
    rmem_i = 1'b1;
    step();
    rmem_i = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("to_pre_valid", valid_o, 0);
    chk("to_pre_mem_rd", mem_rd, 1);
    step();
    chk("to_valid", valid_o, 1);
    chk("to_ir", ir_o, 8'h00);
    chk("to_fault", fault_o, 1);
    chk("to_mem_rd", mem_rd, 0);
    step();

    // Later normal fetch keeps the sticky fault.
    pc_i   = 5'd2;
    rmem_i = 1'b1;
    step();
    rmem_i    = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 8'h62;
    step();
    chk("to_next_ir", ir_o, 8'h62);
    chk("to_sticky", fault_o, 1);
    mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("to_fault_rst", fault_o, 0);
    step();
    reset = 1'b1;
    step();
`else
    // Without the timeout option WAIT lasts indefinitely.
    pc_i   = 5'd31;
    rmem_i = 1'b1;
    step();
    rmem_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("nt_still_wait", mem_rd, 1);
    chk("nt_addr", mem_addr, 31);
    chk("nt_valid", valid_o, 0);
    chk("nt_fault", fault_o, 0);
    mem_ready = 1'b1;
    mem_rdata = 8'h9A;
    step();
    chk("nt_ir", ir_o, 8'h9A);
    chk("nt_opcode", opcode_o, 3'b100);
    chk("nt_operand", operand_o, 5'h1A);
    mem_ready = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage of the accumulator CPU. It sits directly downstream of pc_reg and consumes its registered program counter (pc_o) and memory-read request (rmem_o). It runs a read handshake with instruction memory, latches the returned word into the instruction register and presents it to decode with a valid/stall handshake. It back-pressures the pc unit while a fetch is outstanding.

Parameters:
ADDR_W, 5, program counter / instruction memory address width
DATA_W, 8, instruction width; opcode is the upper DATA_W-ADDR_W bits, operand the lower ADDR_W bits
TIMEOUT, 15, max cycles waiting for mem_ready (used only with FETCH_TIMEOUT_EN)
NOP_WORD, 0, instruction loaded on timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_i  in  ADDR_W  fetch address from pc_reg (pc_o)
rmem_i  in  1  fetch request from pc_reg (rmem_o)
busy_o  out  1  request not accepted this cycle; pc must hold
mem_addr  out  ADDR_W  instruction memory address
mem_rd  out  1  memory read strobe
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  read data valid this cycle
ir_o  out  DATA_W  instruction register
opcode_o  out  DATA_W-ADDR_W  ir_o upper bits
operand_o  out  ADDR_W  ir_o lower bits
valid_o  out  1  ir_o holds an unconsumed instruction
stall_i  in  1  decode not ready
fault_o  out  1  sticky fetch timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mem_addr=0, mem_rd=0, ir_o=0, valid_o=0, fault_o=0, timeout counter=0. Outputs take these values immediately, not at the next edge.
- FSM states: IDLE, WAIT, FULL. All outputs are registered except busy_o.
- IDLE:
  - rmem_i=1 at an edge: mem_addr<=pc_i, mem_rd<=1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - mem_rd=1 and mem_addr are held stable.
  - mem_ready=1 at an edge: ir_o<=mem_rdata, valid_o<=1, mem_rd<=0, go to FULL.
  - mem_ready=0: stay in WAIT.
- FULL:
  - valid_o=1 and ir_o stable while stall_i=1.
  - stall_i=0 at an edge: the instruction is consumed.
  - If rmem_i=1 in that same cycle: mem_addr<=pc_i, mem_rd<=1, valid_o<=0, go to WAIT (back-to-back fetch).
  - Else: valid_o<=0, go to IDLE.
- busy_o = (state==WAIT) | (state==FULL & stall_i). It is combinational.
- rmem_i while busy_o=1 is ignored. The pc unit is required to hold pc_i/rmem_i until busy_o=0.
- Latency: rmem_i sampled at edge N -> mem_rd high after N. mem_ready at edge N+1 -> valid_o high after N+1. Minimum 2 cycles from request to valid instruction.
- opcode_o and operand_o are pure slices of ir_o.
- Reset asserted in WAIT or FULL aborts the fetch: mem_rd drops and the pending instruction is discarded.
- mem_ready outside WAIT is ignored.
- pc wrap-around (31->0) needs no special handling; the address is taken as-is.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments on each WAIT cycle without mem_ready.
  - When the counter reaches TIMEOUT: ir_o<=NOP_WORD, valid_o<=1, mem_rd<=0, fault_o<=1, go to FULL.
  - fault_o is sticky until reset.
  - mem_ready in the same cycle as the timeout wins: normal data is loaded and fault_o is unchanged.
- Undefined: WAIT lasts indefinitely; fault_o is tied 0; no counter logic.

Test Plan:
- Reset: hold reset=0 with mem_ready=1 and rmem_i=1 -> all outputs 0, busy_o=0. Release reset -> first fetch starts at the next edge.
- Single fetch: pc_i=15, rmem_i=1 for 1 cycle; mem_ready one cycle after mem_rd with mem_rdata=8'hAF -> mem_addr=15, ir_o=8'hAF, opcode_o=3'b101, operand_o=5'h0F, valid_o=1 two cycles after request. valid_o clears the cycle after stall_i=0.
- Wait states: mem_ready delayed 4 cycles -> mem_rd and mem_addr stable throughout, busy_o=1 throughout, rmem_i pulse during WAIT ignored.
- Stall and back-to-back: stall_i=1 for 3 cycles in FULL -> ir_o held, busy_o=1. Then stall_i=0 with rmem_i=1, pc_i=16 -> next cycle mem_rd=1, mem_addr=16, valid_o=0.
- Reset mid-fetch: assert reset during WAIT -> mem_rd=0 immediately. After release, a late mem_ready=1 is ignored and valid_o stays 0.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT=15): never assert mem_ready -> after 15 WAIT cycles ir_o=0, valid_o=1, fault_o=1. fault_o stays 1 through later normal fetches until reset.
